// File: rtl/u_stream_pkg.sv
// ============================================================================
// u_stream_pkg : Kyber constants, FSM state type and FIFO entry for u_stream_reader
// Revision 1.0
// ============================================================================
`default_nettype none

package u_stream_pkg;

    localparam int KYBER_Q  = 3329;
    localparam int KYBER_N  = 256;
    localparam int KYBER_DU = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } beat_t;

endpackage

`default_nettype wire

// File: rtl/u_stream_reader_if.sv
// ============================================================================
// u_stream_reader_if : U register-file read port plus valid/ready output stream
// Revision 1.0
// ============================================================================
`default_nettype none

interface u_stream_reader_if;

    logic        read_enable;
    logic        write_enable;
    logic [7:0]  i;
    logic [2:0]  inner_loop;
    logic [15:0] mem_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;

    modport master (
        output read_enable, write_enable, i, inner_loop,
        output out_data, out_valid, out_last,
        input  mem_data, out_ready
    );

    modport slave (
        input  read_enable, write_enable, i, inner_loop,
        input  out_data, out_valid, out_last,
        output mem_data, out_ready
    );

endinterface

`default_nettype wire

// File: rtl/u_compress.sv
// ============================================================================
// u_compress : combinational Kyber du=10 compression, round(x*1024/q) mod 1024
// Only elaborated when U_COMPRESS_EN is defined. Revision 1.0
// ============================================================================
`default_nettype none

`ifdef U_COMPRESS_EN
module u_compress
    import u_stream_pkg::*;
(
    input  logic [11:0]         x,
    output logic [KYBER_DU-1:0] y
);

    logic [21:0] w_scaled;
    logic [21:0] w_quot;
    logic        w_unused_quot;

    // Adding q/2 before the divide turns the floor into round-to-nearest.
    assign w_scaled      = {x, 10'd0} + 22'(KYBER_Q / 2);
    assign w_quot        = w_scaled / 22'(KYBER_Q);
    assign y             = w_quot[KYBER_DU-1:0];
    assign w_unused_quot = ^w_quot[21:KYBER_DU];

endmodule
`endif

`default_nettype wire

// File: rtl/u_stream_reader.sv
// ============================================================================
// u_stream_reader : streams K*256 U coefficients from the register file through
// a 2-entry credit-controlled FIFO. Option: U_COMPRESS_EN. Revision 1.0
// ============================================================================
`default_nettype none

module u_stream_reader
    import u_stream_pkg::*;
#(
    parameter int Kyber_Security = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    u_stream_reader_if.master bus
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_i;
    logic [2:0]  r_inner;
    logic        r_inflight;
    logic        r_inflight_last;
    beat_t       r_fifo [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    logic        w_pop;
    logic        w_push;
    logic [2:0]  w_credit;
    logic        w_last_addr;
    logic        w_rd_en;
    beat_t       w_head;
    logic [15:0] w_word;

    assign w_head      = r_fifo[r_rd_ptr];
    assign w_pop       = (r_count != 2'd0) && bus.out_ready;
    assign w_push      = r_inflight;
    // Slots already claimed (stored + returning next cycle), less the one leaving now.
    assign w_credit    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_last_addr = (r_i == 8'(KYBER_N - 1)) && (r_inner == 3'(Kyber_Security - 1));
    assign w_rd_en     = (r_state == RUN) && (w_credit < 3'd2);

`ifdef U_COMPRESS_EN
    logic [KYBER_DU-1:0] w_cdata;
    logic                w_unused_hi;

    u_compress u_cmp (
        .x (bus.mem_data[11:0]),
        .y (w_cdata)
    );

    assign w_word      = {6'b0, w_cdata};
    assign w_unused_hi = ^bus.mem_data[15:12];
`else
    assign w_word = bus.mem_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_rd_en && w_last_addr) w_state_nxt = DRAIN;
            DRAIN:   if (w_pop && w_head.last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Address walk: i inner, polynomial outer; returns to (0,0) after the final read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i     <= 8'd0;
            r_inner <= 3'd0;
        end else if (w_rd_en) begin
            if (w_last_addr) begin
                r_i     <= 8'd0;
                r_inner <= 3'd0;
            end else if (r_i == 8'(KYBER_N - 1)) begin
                r_i     <= 8'd0;
                r_inner <= r_inner + 3'd1;
            end else begin
                r_i     <= r_i + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_rd_en;
            r_inflight_last <= w_rd_en && w_last_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= '{last: r_inflight_last, data: w_word};
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.read_enable  = w_rd_en;
    assign bus.write_enable = 1'b0;
    assign bus.i            = r_i;
    assign bus.inner_loop   = r_inner;
    assign bus.out_valid    = (r_count != 2'd0);
    assign bus.out_data     = w_head.data;
    assign bus.out_last     = w_head.last && (r_count != 2'd0);

    assign busy = (r_state == RUN) || (r_state == DRAIN);
    assign done = (r_state == DONE);

endmodule

`default_nettype wire
